// File: rtl/ee357_pc_pkg.sv
// Shared encodings for the PC update controller: next-PC source select and FSM states.
package ee357_pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_VEC    = 2'd3
    } pc_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } pc_state_e;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ee357_pc_cond_decode.sv
// PC write request decode: unconditional write, or conditional write on a selectable,
// optionally inverted ALU flag. Selects beyond the flag vector read as a zero flag.
module ee357_pc_cond_decode #(
    parameter int unsigned NCOND = 4,
    localparam int unsigned SelW = (NCOND > 1) ? $clog2(NCOND) : 1
) (
    input  logic             pcw_i,
    input  logic             pcwcond_i,
    input  logic [SelW-1:0]  cond_sel_i,
    input  logic [NCOND-1:0] cond_flags_i,
    input  logic             inv_cond_i,
    output logic             req_o
);

    logic flag;

    // Flag select with out-of-range guard, then request combine (pcw dominates).
    always_comb begin
        flag = 1'b0;
        if (int'(cond_sel_i) < int'(NCOND)) begin
            flag = cond_flags_i[cond_sel_i];
        end
        req_o = pcw_i | (pcwcond_i & (flag ^ inv_cond_i));
    end

endmodule

// File: rtl/ee357_pc_update_ctrl.sv
// Program counter register for the multicycle CPU. Decodes the write request, muxes the
// next-PC source, and holds a redirect requested under stall until the stall releases.
// Optional: define EE357_PC_ALIGN_CHECK_EN to suppress writes of non-word-aligned targets
// and raise a sticky misalign_err_o.
module ee357_pc_update_ctrl
    import ee357_pc_pkg::*;
#(
    parameter int unsigned        PC_W     = 32,
    parameter int unsigned        NCOND    = 4,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    localparam int unsigned       SelW     = (NCOND > 1) ? $clog2(NCOND) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pcw_i,
    input  logic             pcwcond_i,
    input  logic [SelW-1:0]  cond_sel_i,
    input  logic [NCOND-1:0] cond_flags_i,
    input  logic             inv_cond_i,
    input  logic [1:0]       pc_src_i,
    input  logic [PC_W-1:0]  alu_result_i,
    input  logic [PC_W-1:0]  alu_out_i,
    input  logic [PC_W-1:0]  jump_tgt_i,
    input  logic             stall_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             pc_wr_o,
    output logic             pend_o,
    output logic             misalign_err_o
);

    pc_state_e       state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_tgt_q;
    logic            pc_wr_q;

    logic            req;
    logic [PC_W-1:0] tgt;
    logic            wr_go;
    logic [PC_W-1:0] wr_val;
    logic            wr_ok;

    ee357_pc_cond_decode #(
        .NCOND (NCOND)
    ) u_cond_decode (
        .pcw_i        (pcw_i),
        .pcwcond_i    (pcwcond_i),
        .cond_sel_i   (cond_sel_i),
        .cond_flags_i (cond_flags_i),
        .inv_cond_i   (inv_cond_i),
        .req_o        (req)
    );

    // Next-PC source mux.
    always_comb begin
        tgt = RESET_PC;
        unique case (pc_src_e'(pc_src_i))
            PC_SRC_ALU:    tgt = alu_result_i;
            PC_SRC_ALUOUT: tgt = alu_out_i;
            PC_SRC_JUMP:   tgt = jump_tgt_i;
            PC_SRC_VEC:    tgt = RESET_PC;
            default:       tgt = RESET_PC;
        endcase
    end

    // A write lands on an unstalled edge with a live request or a held redirect; a fresh
    // request on the release edge overrides the held target.
    always_comb begin
        wr_go  = !stall_i && (req || (state_q == ST_HELD));
        wr_val = (state_q == ST_HELD && !req) ? pend_tgt_q : tgt;
    end

`ifdef EE357_PC_ALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_d;

    assign wr_ok = is_word_aligned(wr_val[1:0]);

    // Sticky error: set by any suppressed write, cleared only by reset.
    always_comb begin
        misalign_d = misalign_q | (wr_go & ~wr_ok);
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err_o = misalign_q;
`else
    assign wr_ok          = 1'b1;
    assign misalign_err_o = 1'b0;
`endif

    // IDLE/HELD FSM with PC, held target and write pulse as registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pc_wr_q    <= 1'b0;
        end else begin
            pc_wr_q <= 1'b0;
            if (wr_go) begin
                state_q <= ST_IDLE;
                if (wr_ok) begin
                    pc_q    <= wr_val;
                    pc_wr_q <= 1'b1;
                end
            end else if (req) begin
                // Stalled request: capture it; a later stalled request replaces it.
                pend_tgt_q <= tgt;
                state_q    <= ST_HELD;
            end
        end
    end

    assign pc_o    = pc_q;
    assign pc_wr_o = pc_wr_q;
    assign pend_o  = (state_q == ST_HELD);

endmodule

// File: tb/tb_ee357_pc_update_ctrl.sv
// Scoreboard bench for ee357_pc_update_ctrl: directed scenarios then random traffic, with a
// behavioural model pushing expected outputs that a separate monitor compares after each edge.
module tb_ee357_pc_update_ctrl;

    localparam int unsigned    PW  = 32;
    localparam int unsigned    NC  = 4;
    localparam int unsigned    SW  = $clog2(NC);
    localparam logic [PW-1:0]  RPC = 32'h100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pcw, pcwcond, inv_cond, stall;
    logic [SW-1:0] cond_sel;
    logic [NC-1:0] cond_flags;
    logic [1:0]    pc_src;
    logic [PW-1:0] alu_result, alu_out, jump_tgt;
    logic [PW-1:0] pc;
    logic          pc_wr, pend, misalign_err;

    always #5 clk = ~clk;

    ee357_pc_update_ctrl #(
        .PC_W     (PW),
        .NCOND    (NC),
        .RESET_PC (RPC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pcw_i          (pcw),
        .pcwcond_i      (pcwcond),
        .cond_sel_i     (cond_sel),
        .cond_flags_i   (cond_flags),
        .inv_cond_i     (inv_cond),
        .pc_src_i       (pc_src),
        .alu_result_i   (alu_result),
        .alu_out_i      (alu_out),
        .jump_tgt_i     (jump_tgt),
        .stall_i        (stall),
        .pc_o           (pc),
        .pc_wr_o        (pc_wr),
        .pend_o         (pend),
        .misalign_err_o (misalign_err)
    );

    typedef struct {
        logic          rst_n;
        logic          pcw;
        logic          pcwcond;
        logic [SW-1:0] sel;
        logic [NC-1:0] flags;
        logic          inv;
        logic [1:0]    src;
        logic [PW-1:0] ares;
        logic [PW-1:0] aout;
        logic [PW-1:0] jmp;
        logic          stall;
    } stim_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic          wr;
        logic          pend;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: architectural PC, whether a redirect is outstanding and where to.
    logic [PW-1:0] m_pc;
    logic          m_wr;
    logic          m_have_redirect;
    logic [PW-1:0] m_redirect;
    logic          m_err;

    function automatic stim_t quiet();
        stim_t s;
        s.rst_n = 1'b1; s.pcw = 1'b0; s.pcwcond = 1'b0; s.sel = '0; s.flags = '0;
        s.inv = 1'b0; s.src = 2'd0; s.ares = '0; s.aout = '0; s.jmp = '0; s.stall = 1'b0;
        return s;
    endfunction

    function automatic void model(input stim_t s);
        logic          flag;
        logic          want;
        logic [PW-1:0] dest;
        logic [PW-1:0] cand[4];
        cand[0] = s.ares; cand[1] = s.aout; cand[2] = s.jmp; cand[3] = RPC;
        if (!s.rst_n) begin
            m_pc = RPC; m_wr = 1'b0; m_have_redirect = 1'b0; m_redirect = '0; m_err = 1'b0;
            return;
        end
        flag = (int'(s.sel) < int'(NC)) ? s.flags[s.sel] : 1'b0;
        want = s.pcw || (s.pcwcond && (flag != s.inv));
        m_wr = 1'b0;
        if (s.stall) begin
            if (want) begin
                m_have_redirect = 1'b1;
                m_redirect      = cand[s.src];
            end
        end else if (want || m_have_redirect) begin
            dest            = want ? cand[s.src] : m_redirect;
            m_have_redirect = 1'b0;
`ifdef EE357_PC_ALIGN_CHECK_EN
            if (dest % 4 != 0) begin
                m_err = 1'b1;
            end else begin
                m_pc = dest; m_wr = 1'b1;
            end
`else
            m_pc = dest; m_wr = 1'b1;
`endif
        end
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = s.rst_n; pcw = s.pcw; pcwcond = s.pcwcond; cond_sel = s.sel;
        cond_flags = s.flags; inv_cond = s.inv; pc_src = s.src; alu_result = s.ares;
        alu_out = s.aout; jump_tgt = s.jmp; stall = s.stall;
        model(s);
        e.pc = m_pc; e.wr = m_wr; e.pend = m_have_redirect; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    // Monitor: after every edge, compare DUT outputs with the oldest expected entry.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_wr", {31'd0, pc_wr}, {31'd0, e.wr});
            chk("pend", {31'd0, pend}, {31'd0, e.pend});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
        end
    end

    initial begin
        stim_t s;
        s = quiet();
        s.rst_n = 1'b0;
        apply(s);
        apply(s);

        // Condition matrix on flag 1.
        s = quiet(); s.pcwcond = 1'b1; s.sel = 2'd1; s.flags = 4'b0010; s.aout = 32'h40;
        s.src = 2'd1;
        apply(s);
        apply(quiet());
        s.inv = 1'b1; s.aout = 32'h44;
        apply(s);
        apply(quiet());
        s = quiet(); s.pcw = 1'b1; s.pcwcond = 1'b1; s.sel = 2'd1; s.src = 2'd1;
        s.aout = 32'h48;
        apply(s);
        apply(quiet());

        // Stall hold then release.
        s = quiet(); s.stall = 1'b1; s.pcw = 1'b1; s.jmp = 32'h80; s.src = 2'd2;
        apply(s);
        s.pcw = 1'b0;
        repeat (3) apply(s);
        apply(quiet());
        apply(quiet());

        // Latest request wins.
        s = quiet(); s.stall = 1'b1; s.pcw = 1'b1; s.jmp = 32'h80; s.src = 2'd2;
        apply(s);
        s.jmp = 32'hC0;
        apply(s);
        s.stall = 1'b0; s.jmp = 32'h20;
        apply(s);
        apply(quiet());

        // Reset while a redirect is held discards it.
        s = quiet(); s.stall = 1'b1; s.pcw = 1'b1; s.jmp = 32'h80; s.src = 2'd2;
        apply(s);
        s.rst_n = 1'b0; s.pcw = 1'b0;
        apply(s);
        s.rst_n = 1'b1; s.stall = 1'b0;
        apply(s);
        apply(quiet());

        // Vector source and back-to-back unstalled writes.
        s = quiet(); s.pcw = 1'b1; s.src = 2'd3;
        apply(s);
        s.src = 2'd0; s.ares = 32'h200;
        apply(s);
        apply(quiet());

`ifdef EE357_PC_ALIGN_CHECK_EN
        s = quiet(); s.pcw = 1'b1; s.src = 2'd0; s.ares = 32'h42;
        apply(s);
        s.ares = 32'h44;
        apply(s);
        apply(quiet());
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n   = ($urandom_range(63) != 0);
            s.pcw     = ($urandom_range(3) == 0);
            s.pcwcond = ($urandom_range(1) == 0);
            s.sel     = SW'($urandom);
            s.flags   = NC'($urandom);
            s.inv     = ($urandom_range(1) == 0);
            s.src     = 2'($urandom);
            s.ares    = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.aout    = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.jmp     = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.stall   = ($urandom_range(2) == 0);
            apply(s);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ee357_pc_update_ctrl.md
# ee357_pc_update_ctrl

Parametrised successor to the single-condition PC write-enable logic. The block owns the program counter register of the multicycle CPU. It decodes the PC write decision from N selectable condition flags with optional inversion, muxes the next-PC source, and holds a redirect requested during a stall until the stall releases. It sits between the control FSM/ALU and the instruction-fetch address port.

## Interface
Parameters:
- `PC_W`, 32: PC and target width; minimum 4.
- `NCOND`, 4: number of condition flags (zero, neg, carry, overflow); minimum 2.
- `RESET_PC`, 0: PC value after reset and for `pc_src`=3.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pcw` in 1: unconditional PC write.
- `pcwcond` in 1: conditional PC write.
- `cond_sel` in $clog2(NCOND): selects a flag from `cond_flags`.
- `cond_flags` in NCOND: ALU condition flags.
- `inv_cond` in 1: inverts the selected flag.
- `pc_src` in 2: target select. 0 `alu_result`, 1 `alu_out`, 2 `jump_tgt`, 3 `RESET_PC`.
- `alu_result`, `alu_out`, `jump_tgt` in PC_W: candidate targets.
- `stall` in 1: PC update blocked this cycle.
- `pc` out PC_W: current PC (registered).
- `pc_wr` out 1: one-cycle pulse, coincident with a new `pc` value.
- `pend` out 1: a redirect is held.
- `misalign_err` out 1: sticky alignment error (see Configuration).

## Operation
- Request: `req = pcw | (pcwcond & (flag ^ inv_cond))`.
  - `flag = cond_flags[cond_sel]`.
  - If `cond_sel` ≥ NCOND, `flag` = 0 (so `req = pcw | (pcwcond & inv_cond)`).
- `tgt` = `pc_src`-selected value. Muxing is combinational and sampled on the edge.
- State machine `IDLE` / `HELD`:
  - IDLE, `req` & !`stall`: `pc` <= `tgt`, `pc_wr` <= 1. Stay in IDLE.
  - IDLE, `req` & `stall`: `pend_tgt` <= `tgt`. Go to HELD.
  - IDLE, !`req`: hold `pc`, `pc_wr` <= 0.
  - HELD, `stall`: if `req`, `pend_tgt` <= `tgt` (latest request wins). Otherwise hold.
  - HELD, !`stall`: `pc` <= (`req` ? `tgt` : `pend_tgt`), `pc_wr` <= 1. Go to IDLE.
- `pend` = (state == HELD).
- `pcw` and `pcwcond` both high: `pcw` dominates, so the write happens regardless of the flag.
- Reset mid-HELD discards the held target and returns to IDLE.

## Timing
- Reset values: `pc`=RESET_PC, `pc_wr`=0, `pend`=0, `misalign_err`=0, state IDLE, `pend_tgt`=0.
- Reset has priority over every other input on the same edge.
- Latency: a request at edge k (no stall) gives the new `pc` and `pc_wr`=1 after edge k.
- A held redirect applies on the first edge where `stall`=0.
- `pc_wr` is never high for two consecutive cycles unless requests occur on consecutive unstalled edges.
- No combinational path from inputs to outputs.

## Configuration
- `EE357_PC_ALIGN_CHECK_EN` defined:
  - When a write is about to be applied, it is checked against `tgt[1:0]` (or `pend_tgt[1:0]` for a held redirect).
  - If those bits are ≠ 0, the write is suppressed: `pc` unchanged, `pc_wr`=0, state returns to IDLE.
  - `misalign_err` <= 1 and stays high until reset.
- Undefined: `misalign_err` is tied to 0 and all target bits are written unchanged.

## Structure
- Package `ee357_pc_pkg`:
  - `pc_src` encodings: `PC_SRC_ALU`=0, `PC_SRC_ALUOUT`=1, `PC_SRC_JUMP`=2, `PC_SRC_VEC`=3.
  - State encodings: `ST_IDLE`, `ST_HELD`.
- One sub-module, `ee357_pc_cond_decode`:
  - Combinational: `pcw`, `pcwcond`, `cond_sel`, `cond_flags`, `inv_cond` -> `req`.
  - Parametrised on NCOND.
- The register, FSM and mux stay in the top module.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with RESET_PC=0x100 -> `pc`=0x100, `pc_wr`=0, `pend`=0.
- Condition matrix:
  - Setup: `pcwcond`=1, `cond_sel`=1, `cond_flags`=4'b0010, `alu_out`=0x40, `pc_src`=1.
  - `inv_cond`=0 -> `pc`=0x40 with a one-cycle `pc_wr`.
  - `inv_cond`=1 -> no write.
  - `pcw`=1 with `cond_flags`=0 -> write.
- Stall hold:
  - `stall`=1, `pcw`=1, `jump_tgt`=0x80, `pc_src`=2 for one cycle, then `pcw`=0 for 3 stalled cycles.
  - `pend`=1 throughout and `pc` unchanged.
  - `stall`=0 -> `pc`=0x80 and `pend`=0 after one edge.
- Latest wins: while HELD with 0x80, a new stalled request for 0xC0 arrives, then the stall drops together with a request for 0x20 -> `pc`=0x20.
- Reset mid-HELD: with `pend`=1, `rst_n`=0 for one edge -> `pend`=0 and `pc`=RESET_PC. The held target is not applied after the stall releases.
- With `EE357_PC_ALIGN_CHECK_EN`: `pcw`=1, `alu_result`=0x42, `pc_src`=0 -> `pc` unchanged, `pc_wr`=0, `misalign_err`=1, and it stays set after an aligned write to 0x44.
